// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions.
//   width_e  : RV32I funct3 width codes for loads and stores
//   state_e  : LSU control FSM states
//   op_legal : opcode legality plus natural-alignment check
package lsu_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } width_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WB,
        S_ERR
    } state_e;

    // The unsigned widths exist only for loads. Half accesses need an even
    // address. Word accesses need a word-aligned address.
    function automatic logic op_legal(input logic       is_store,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
        logic ok;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            F3_BU:   ok = ~is_store;
            F3_HU:   ok = ~is_store & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_aligner.sv
// Load lane extraction. Selects the addressed byte or halfword from a
// 32-bit memory word, then sign-extends or zero-extends it per funct3.
//   rdata  : 32-bit word read from memory
//   addr   : low two bits of the byte address
//   funct3 : load width code
//   value  : value to write back to the register file
module load_aligner
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[{addr, 3'b000} +: 8];
        lane_h = addr[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    value = {{24{lane_b[7]}}, lane_b};
            F3_BU:   value = {24'b0, lane_b};
            F3_H:    value = {{16{lane_h[15]}}, lane_h};
            F3_HU:   value = {16'b0, lane_h};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding-op RV32I load/store unit.
// Control side : start, is_store, funct3, addr, store_data, rd_addr_in
//                -> busy, done, fault
// Memory side  : mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
//                <- mem_ready, mem_rdata
// Register file: rd_addr, rd_data, reg_write_enable
// All outputs decode from registered state. Async reset therefore forces
// every output low immediately.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_addr_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        reg_write_enable,
    output logic        busy,
    output logic        done,
    output logic        fault
);

    localparam int             CW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  TMO = CW'(TIMEOUT_CYCLES);

    state_e        state_q, state_d;
    logic          is_store_q, is_store_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   sdata_q, sdata_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // A store finishes in IDLE, so its done pulse needs its own flop.
    // Start is not accepted in that cycle.
    logic          sdone_q, sdone_d;
    logic [31:0]   load_value;

    load_aligner u_align (
        .rdata  (rdata_q),
        .addr   (addr_q[1:0]),
        .funct3 (funct3_q),
        .value  (load_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b0;
            addr_q     <= 32'b0;
            sdata_q    <= 32'b0;
            rd_q       <= 5'b0;
            rdata_q    <= 32'b0;
            cnt_q      <= '0;
            sdone_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            sdata_q    <= sdata_d;
            rd_q       <= rd_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
            sdone_q    <= sdone_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        rd_d       = rd_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
        sdone_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !sdone_q) begin
                    is_store_d = is_store;
                    funct3_d   = funct3;
                    addr_d     = addr;
                    sdata_d    = store_data;
                    rd_d       = rd_addr_in;
                    cnt_d      = '0;
                    state_d    = op_legal(is_store, funct3, addr[1:0]) ? S_REQ : S_ERR;
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    if (is_store_q) begin
                        state_d = S_IDLE;
                        sdone_d = 1'b1;
                    end else begin
                        rdata_d = mem_rdata;
                        state_d = S_WB;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == TMO - CW'(1)) state_d = S_ERR;
                end
            end
            default: state_d = S_IDLE;  // S_WB and S_ERR each last one cycle
        endcase
    end

    always_comb begin
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = 32'b0;
        mem_wdata        = 32'b0;
        mem_wmask        = 4'b0;
        rd_addr          = 5'b0;
        rd_data          = 32'b0;
        reg_write_enable = 1'b0;
        busy             = (state_q != S_IDLE);
        done             = sdone_q | (state_q == S_WB) | (state_q == S_ERR);
        fault            = (state_q == S_ERR);
        case (state_q)
            S_REQ: begin
                mem_req  = 1'b1;
                mem_we   = is_store_q;
                mem_addr = {addr_q[31:2], 2'b00};
                if (is_store_q) begin
                    case (funct3_q)
                        F3_B: begin
                            mem_wdata = {4{sdata_q[7:0]}};
                            mem_wmask = 4'b0001 << addr_q[1:0];
                        end
                        F3_H: begin
                            mem_wdata = {2{sdata_q[15:0]}};
                            mem_wmask = addr_q[1] ? 4'b1100 : 4'b0011;
                        end
                        default: begin
                            mem_wdata = sdata_q;
                            mem_wmask = 4'b1111;
                        end
                    endcase
                end
            end
            S_WB: begin
                rd_addr          = rd_q;
                rd_data          = load_value;
                reg_write_enable = (rd_q != 5'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start = 1'b0, is_store = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] addr = 32'b0, store_data = 32'b0;
    logic [4:0]  rd_addr_in = 5'b0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'b0;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        reg_write_enable, busy, done, fault;

    load_store_unit #(.TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .rd_addr_in(rd_addr_in), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .rd_addr(rd_addr),
        .rd_data(rd_data), .reg_write_enable(reg_write_enable),
        .busy(busy), .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a, sd;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          wt;
        logic        flt, we;
        logic [31:0] rdd, wdat;
        logic [3:0]  wm;
    } vec_t;

    typedef struct {
        logic        flt, we;
        logic [4:0]  rd;
        logic [31:0] rdd;
        int          lat, nreq;
    } exp_t;

    exp_t sb[$];

    function automatic vec_t mk(input logic st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] sd,
                                input logic [4:0] rd, input logic [31:0] rdata,
                                input int wt, input logic flt, input logic we,
                                input logic [31:0] rdd, input logic [31:0] wdat,
                                input logic [3:0] wm);
        vec_t v;
        v.st = st; v.f3 = f3; v.a = a; v.sd = sd; v.rd = rd; v.rdata = rdata;
        v.wt = wt; v.flt = flt; v.we = we; v.rdd = rdd; v.wdat = wdat; v.wm = wm;
        return v;
    endfunction

    // Issue one op, push the expected completion, then answer memory requests
    // after v.wt wait cycles and pop/compare when done appears.
    task automatic run_vec(input vec_t v, input string tag, input int lat, input int nreq);
        exp_t e;
        int   cyc, reqc;
        bit   seen;
        e.flt = v.flt; e.we = v.we; e.rd = v.rd; e.rdd = v.rdd; e.lat = lat; e.nreq = nreq;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1; is_store = v.st; funct3 = v.f3; addr = v.a;
        store_data = v.sd; rd_addr_in = v.rd; mem_rdata = v.rdata;
        cyc = 0; reqc = 0; seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            start = 1'b0; mem_ready = 1'b0; cyc++;
            if (mem_req) begin
                if (reqc == 0) begin
                    chk({tag, "_mem_we"},    {31'b0, mem_we}, {31'b0, v.st});
                    chk({tag, "_mem_addr"},  mem_addr, {v.a[31:2], 2'b00});
                    chk({tag, "_mem_wdata"}, mem_wdata, v.wdat);
                    chk({tag, "_mem_wmask"}, {28'b0, mem_wmask}, {28'b0, v.wm});
                end
                if (reqc == v.wt) mem_ready = 1'b1;
                reqc++;
            end
            if (done) begin
                exp_t x;
                seen = 1'b1;
                x = sb.pop_front();
                chk({tag, "_fault"},   {31'b0, fault}, {31'b0, x.flt});
                chk({tag, "_rwe"},     {31'b0, reg_write_enable}, {31'b0, x.we});
                chk({tag, "_latency"}, cyc, x.lat);
                chk({tag, "_nreq"},    reqc, x.nreq);
                if (x.we) begin
                    chk({tag, "_rd_data"}, rd_data, x.rdd);
                    chk({tag, "_rd_addr"}, {27'b0, rd_addr}, {27'b0, x.rd});
                end
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s_no_done waited=%0d cycles required=done", tag, cyc);
            void'(sb.pop_front());
        end
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        chk({tag, "_rwe_pulse"},  {31'b0, reg_write_enable}, 32'd0);
    endtask

    vec_t vecs[15];

    initial begin
        vecs[0]  = mk(0, 3'b000, 32'h103, 0, 5, 32'h80FF1234, 0, 0, 1, 32'hFFFFFF80, 0, 0);
        vecs[1]  = mk(1, 3'b001, 32'h102, 32'h0000ABCD, 0, 0, 0, 0, 0, 0, 32'hABCDABCD, 4'b1100);
        vecs[2]  = mk(0, 3'b010, 32'h101, 0, 4, 0, 0, 1, 0, 0, 0, 0);
        vecs[3]  = mk(0, 3'b101, 32'h2, 0, 0, 32'h80010000, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(0, 3'b101, 32'h2, 0, 7, 32'h80010000, 0, 0, 1, 32'h00008001, 0, 0);
        vecs[5]  = mk(0, 3'b010, 32'h200, 0, 10, 32'hDEADBEEF, 3, 0, 1, 32'hDEADBEEF, 0, 0);
        vecs[6]  = mk(1, 3'b000, 32'h101, 32'h123456A5, 0, 0, 0, 0, 0, 0, 32'hA5A5A5A5, 4'b0010);
        vecs[7]  = mk(1, 3'b010, 32'h104, 32'hCAFEF00D, 0, 0, 1, 0, 0, 0, 32'hCAFEF00D, 4'b1111);
        vecs[8]  = mk(0, 3'b001, 32'h0, 0, 12, 32'h1234F00F, 2, 0, 1, 32'hFFFFF00F, 0, 0);
        vecs[9]  = mk(0, 3'b100, 32'h102, 0, 13, 32'h00AB0000, 0, 0, 1, 32'h000000AB, 0, 0);
        vecs[10] = mk(1, 3'b011, 32'h0, 32'h1, 0, 0, 0, 1, 0, 0, 0, 0);
        vecs[11] = mk(0, 3'b110, 32'h0, 0, 3, 0, 0, 1, 0, 0, 0, 0);
        vecs[12] = mk(1, 3'b001, 32'h3, 32'h55, 0, 0, 0, 1, 0, 0, 0, 0);
        vecs[13] = mk(0, 3'b000, 32'h1, 0, 31, 32'h00007F00, 1, 0, 1, 32'h0000007F, 0, 0);
        vecs[14] = mk(1, 3'b100, 32'h0, 32'h1, 0, 0, 0, 1, 0, 0, 0, 0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy",    {31'b0, busy}, 32'd0);
        chk("rst_done",    {31'b0, done}, 32'd0);
        chk("rst_fault",   {31'b0, fault}, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_rwe",     {31'b0, reg_write_enable}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;

        // mem_ready while idle must not start anything
        @(negedge clk); mem_ready = 1'b1;
        @(negedge clk);
        chk("idle_ready_busy", {31'b0, busy}, 32'd0);
        chk("idle_ready_done", {31'b0, done}, 32'd0);
        mem_ready = 1'b0;

        for (int i = 0; i < 15; i++) begin
            string t;
            t = $sformatf("v%0d", i);
            run_vec(vecs[i], t, vecs[i].flt ? 1 : 2 + vecs[i].wt, vecs[i].flt ? 0 : vecs[i].wt + 1);
        end

        // Timeout: memory never answers
        run_vec(mk(0, 3'b010, 32'h40, 0, 6, 0, 100000, 1, 0, 0, 0, 0), "timeout", 65, 64);

        // Reset in the middle of a stalled request
        begin
            int bad;
            @(negedge clk);
            start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h300; rd_addr_in = 5'd9;
            mem_rdata = 32'h11112222;
            @(negedge clk); start = 1'b0;
            repeat (2) @(negedge clk);
            chk("mid_req_before", {31'b0, mem_req}, 32'd1);
            #1 rst_n = 1'b0;
            #1;
            chk("mid_rst_mem_req", {31'b0, mem_req}, 32'd0);
            chk("mid_rst_busy",    {31'b0, busy}, 32'd0);
            @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1;
            bad = 0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (reg_write_enable || done || busy) bad++;
            end
            chk("mid_rst_no_write", bad, 0);
            mem_ready = 1'b0;
        end

        // First start accepted on the first edge after reset release
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; start = 1'b1; is_store = 1'b0; funct3 = 3'b000; addr = 32'h7;
        rd_addr_in = 5'd2; mem_rdata = 32'h81000000;
        @(negedge clk);
        start = 1'b0;
        chk("rel_busy",    {31'b0, busy}, 32'd1);
        chk("rel_mem_req", {31'b0, mem_req}, 32'd1);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("rel_rwe",     {31'b0, reg_write_enable}, 32'd1);
        chk("rel_rd_data", rd_data, 32'hFFFFFF81);

        // Start is ignored in REQ and in the store done cycle, then accepted
        @(negedge clk);
        start = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h10; store_data = 32'h5;
        @(negedge clk);
        is_store = 1'b0; funct3 = 3'b010; addr = 32'h20; rd_addr_in = 5'd3;
        mem_rdata = 32'h0BADF00D; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("ign_done",  {31'b0, done}, 32'd1);
        chk("ign_busy0", {31'b0, busy}, 32'd0);
        @(negedge clk);
        chk("ign_not_taken", {31'b0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("ign_taken_busy", {31'b0, busy}, 32'd1);
        chk("ign_taken_addr", mem_addr, 32'h20);
        chk("ign_taken_we",   {31'b0, mem_we}, 32'd0);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("ign_wb_rwe",  {31'b0, reg_write_enable}, 32'd1);
        chk("ign_wb_rd",   {27'b0, rd_addr}, 32'd3);
        chk("ign_wb_data", rd_data, 32'h0BADF00D);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
